// File: rtl/ghist_checkpoint_ctrl_pkg.sv
// Shared types for the branch-history checkpoint queue: entry layout and default depth.
package ghist_checkpoint_ctrl_pkg;

   localparam int CKPT_DEPTH  = 16;
   localparam int GHIST_WIDTH = 8;
   localparam int FOLD_WIDTH  = 64;

   typedef logic [FOLD_WIDTH-1:0] fold_hist_t;

   typedef struct packed {
      logic [GHIST_WIDTH-1:0] ghist_idx;
      fold_hist_t             fold;
   } hist_ckpt_t;

endpackage

// File: rtl/ghist_checkpoint_ctrl_ptr_range.sv
// Combinational live-range check: is idx one of the entries in [head, tail-1] modulo depth?
module ckpt_ptr_range #(
   parameter int IDX_W = 4
) (
   input  logic [IDX_W:0]   head,
   input  logic [IDX_W:0]   tail,
   input  logic [IDX_W-1:0] idx,
   output logic             in_range
);

   logic [IDX_W:0]   live_cnt;
   logic [IDX_W-1:0] off;

   // Distance from head, measured in the index ring, must be below the live count.
   assign live_cnt = tail - head;
   assign off      = idx - head[IDX_W-1:0];
   assign in_range = ({1'b0, off} < live_cnt);

endmodule

// File: rtl/ghist_checkpoint_ctrl.sv
// Circular checkpoint queue of {ghist position, folded history}, with s2 overwrite,
// commit, and squash rollback that drives registered restore values.
module ghist_checkpoint_ctrl
   import ghist_checkpoint_ctrl_pkg::*;
#(
   parameter int DEPTH = CKPT_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enq_valid,
   output logic                   enq_ready,
   input  logic [GHIST_WIDTH-1:0] enq_ghist_idx,
   input  logic [FOLD_WIDTH-1:0]  enq_fold,
   output logic [IDX_W-1:0]       enq_idx,
   input  logic                   s2_redirect,
   input  logic [GHIST_WIDTH-1:0] s2_ghist_idx,
   input  logic [FOLD_WIDTH-1:0]  s2_fold,
   input  logic                   commit_en,
   input  logic                   squash_en,
   input  logic [IDX_W-1:0]       squash_idx,
   output logic                   restore_valid,
   output logic [GHIST_WIDTH-1:0] restore_ghist_idx,
   output logic [FOLD_WIDTH-1:0]  restore_fold,
   output logic [IDX_W:0]         count,
   output logic                   squash_err
);

   localparam logic [IDX_W:0]   PTR_ONE = 1;
   localparam logic [IDX_W-1:0] IDX_ONE = 1;

   hist_ckpt_t entries [DEPTH];

   logic [IDX_W:0]   head;
   logic [IDX_W:0]   tail;
   logic [IDX_W:0]   sq_tail;
   logic [IDX_W-1:0] sq_off;
   logic [IDX_W-1:0] last_idx;
   logic             empty;
   logic             full;
   logic             sq_in_range;
   logic             sq_ok;
   logic             do_enq;
   logic             do_s2;
   logic             do_commit;

   assign empty     = (head == tail);
   assign full      = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
   assign count     = tail - head;
   assign enq_ready = ~full;
   assign enq_idx   = tail[IDX_W-1:0];
   assign last_idx  = tail[IDX_W-1:0] - IDX_ONE;

   ckpt_ptr_range #(.IDX_W(IDX_W)) u_range (
      .head     (head),
      .tail     (tail),
      .idx      (squash_idx),
      .in_range (sq_in_range)
   );

   // The squashed entry stays live, so the new tail sits one past it, measured
   // from the pre-commit head so the wrap bit comes out right.
   assign sq_off  = squash_idx - head[IDX_W-1:0];
   assign sq_tail = head + {1'b0, sq_off} + PTR_ONE;
   assign sq_ok   = squash_en & sq_in_range;

   assign do_s2     = s2_redirect & ~squash_en & ~empty;
   assign do_enq    = enq_valid & ~full & ~squash_en & ~s2_redirect;
   assign do_commit = commit_en & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (sq_ok) begin
            tail <= sq_tail;
         end else if (do_enq) begin
            tail <= tail + PTR_ONE;
         end
         if (do_commit) begin
            head <= head + PTR_ONE;
         end
      end
   end

   // Checkpoint storage carries no reset; only live entries are ever read.
   always_ff @(posedge clk) begin
      if (do_s2) begin
         entries[last_idx] <= '{ghist_idx: s2_ghist_idx, fold: s2_fold};
      end else if (do_enq) begin
         entries[tail[IDX_W-1:0]] <= '{ghist_idx: enq_ghist_idx, fold: enq_fold};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         restore_valid     <= 1'b0;
         restore_ghist_idx <= '0;
         restore_fold      <= '0;
         squash_err        <= 1'b0;
      end else begin
         restore_valid <= sq_ok;
         squash_err    <= squash_en & ~sq_in_range;
         if (sq_ok) begin
            restore_ghist_idx <= entries[squash_idx].ghist_idx;
            restore_fold      <= entries[squash_idx].fold;
         end
      end
   end

endmodule

// File: tb/tb_ghist_checkpoint_ctrl.sv
// Randomized and directed bench for ghist_checkpoint_ctrl against a queue-based reference model.
module tb_ghist_checkpoint_ctrl;
   import ghist_checkpoint_ctrl_pkg::*;

   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic                   clk;
   logic                   rst;
   logic                   enq_valid;
   logic                   enq_ready;
   logic [GHIST_WIDTH-1:0] enq_ghist_idx;
   logic [FOLD_WIDTH-1:0]  enq_fold;
   logic [IDX_W-1:0]       enq_idx;
   logic                   s2_redirect;
   logic [GHIST_WIDTH-1:0] s2_ghist_idx;
   logic [FOLD_WIDTH-1:0]  s2_fold;
   logic                   commit_en;
   logic                   squash_en;
   logic [IDX_W-1:0]       squash_idx;
   logic                   restore_valid;
   logic [GHIST_WIDTH-1:0] restore_ghist_idx;
   logic [FOLD_WIDTH-1:0]  restore_fold;
   logic [IDX_W:0]         count;
   logic                   squash_err;

   ghist_checkpoint_ctrl #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .enq_valid         (enq_valid),
      .enq_ready         (enq_ready),
      .enq_ghist_idx     (enq_ghist_idx),
      .enq_fold          (enq_fold),
      .enq_idx           (enq_idx),
      .s2_redirect       (s2_redirect),
      .s2_ghist_idx      (s2_ghist_idx),
      .s2_fold           (s2_fold),
      .commit_en         (commit_en),
      .squash_en         (squash_en),
      .squash_idx        (squash_idx),
      .restore_valid     (restore_valid),
      .restore_ghist_idx (restore_ghist_idx),
      .restore_fold      (restore_fold),
      .count             (count),
      .squash_err        (squash_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: live entries oldest-first plus absolute head sequence number
   typedef struct {
      logic [GHIST_WIDTH-1:0] g;
      logic [FOLD_WIDTH-1:0]  f;
   } rec_t;

   rec_t                   mq[$];
   int                     head_seq;
   logic                   m_rv;
   logic [GHIST_WIDTH-1:0] m_rg;
   logic [FOLD_WIDTH-1:0]  m_rf;
   logic                   m_err;

   int n_tests;
   int n_fail;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      head_seq = 0;
      m_rv = 0; m_rg = '0; m_rf = '0; m_err = 0;
   endtask

   task automatic model_step();
      int   live;
      int   k;
      rec_t r;
      live = mq.size();
      if (squash_en) begin
         k = (int'(squash_idx) - (head_seq % DEPTH) + DEPTH) % DEPTH;
         if (k < live) begin
            m_rv = 1; m_err = 0;
            m_rg = mq[k].g; m_rf = mq[k].f;
            while (mq.size() > k + 1) void'(mq.pop_back());
         end else begin
            m_rv = 0; m_err = 1;
         end
      end else begin
         m_rv = 0; m_err = 0;
         if (s2_redirect) begin
            if (live > 0) begin
               r.g = s2_ghist_idx; r.f = s2_fold;
               mq[live-1] = r;
            end
         end else if (enq_valid && live < DEPTH) begin
            r.g = enq_ghist_idx; r.f = enq_fold;
            mq.push_back(r);
         end
      end
      if (commit_en && live > 0) begin
         void'(mq.pop_front());
         head_seq++;
      end
   endtask

   task automatic check_state(input string pfx);
      chk({pfx, ".count"}, 64'(count), 64'(mq.size()));
      chk({pfx, ".enq_ready"}, 64'(enq_ready), 64'(mq.size() < DEPTH));
      chk({pfx, ".enq_idx"}, 64'(enq_idx), 64'((head_seq + mq.size()) % DEPTH));
   endtask

   // driver: apply one cycle of inputs, advance the model, check after the edge
   task automatic drive(input logic ev, input logic [GHIST_WIDTH-1:0] eg,
                        input logic s2, input logic [GHIST_WIDTH-1:0] s2g,
                        input logic cm, input logic sq, input logic [IDX_W-1:0] sqi);
      enq_valid = ev; enq_ghist_idx = eg; enq_fold = {$urandom, $urandom};
      s2_redirect = s2; s2_ghist_idx = s2g; s2_fold = {$urandom, $urandom};
      commit_en = cm; squash_en = sq; squash_idx = sqi;
      #1;
      check_state("pre");
      model_step();
      @(posedge clk);
      #1;
      check_state("post");
      chk("restore_valid", 64'(restore_valid), 64'(m_rv));
      chk("squash_err", 64'(squash_err), 64'(m_err));
      chk("restore_ghist", 64'(restore_ghist_idx), 64'(m_rg));
      chk("restore_fold", restore_fold, m_rf);
   endtask

   task automatic idle();
      drive(0, '0, 0, '0, 0, 0, '0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst.count", 64'(count), 64'd0);
      chk("rst.restore_valid", 64'(restore_valid), 64'd0);
      chk("rst.restore_ghist", 64'(restore_ghist_idx), 64'd0);
      chk("rst.restore_fold", restore_fold, 64'd0);
      chk("rst.squash_err", 64'(squash_err), 64'd0);
      chk("rst.enq_ready", 64'(enq_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      enq_valid = 0; enq_ghist_idx = '0; enq_fold = '0;
      s2_redirect = 0; s2_ghist_idx = '0; s2_fold = '0;
      commit_en = 0; squash_en = 0; squash_idx = '0;
      do_reset();

      // three enqueues
      drive(1, 8'd5, 0, '0, 0, 0, '0);
      drive(1, 8'd9, 0, '0, 0, 0, '0);
      drive(1, 8'd12, 0, '0, 0, 0, '0);
      chk("three.count", 64'(count), 64'd3);
      chk("three.enq_idx", 64'(enq_idx), 64'd3);

      // fill, overflow attempt, commit+enq while full
      for (int i = 0; i < 13; i++) drive(1, 8'(20 + i), 0, '0, 0, 0, '0);
      chk("full.enq_ready", 64'(enq_ready), 64'd0);
      drive(1, 8'd99, 0, '0, 0, 0, '0);
      chk("full.drop", 64'(count), 64'd16);
      drive(1, 8'd98, 0, '0, 1, 0, '0);
      chk("full.commit_enq", 64'(count), 64'd15);

      // squash idx 1 with five live entries
      do_reset();
      drive(1, 8'd5, 0, '0, 0, 0, '0);
      drive(1, 8'd9, 0, '0, 0, 0, '0);
      for (int i = 0; i < 3; i++) drive(1, 8'(40 + i), 0, '0, 0, 0, '0);
      drive(0, '0, 0, '0, 0, 1, 4'd1);
      chk("sq1.ghist", 64'(restore_ghist_idx), 64'd9);
      chk("sq1.count", 64'(count), 64'd2);
      idle();
      chk("sq1.pulse", 64'(restore_valid), 64'd0);

      // s2 redirect overrides a same-cycle enqueue
      do_reset();
      drive(1, 8'd5, 0, '0, 0, 0, '0);
      drive(1, 8'd9, 0, '0, 0, 0, '0);
      drive(1, 8'd77, 1, 8'd33, 0, 0, '0);
      chk("s2.count", 64'(count), 64'd2);
      drive(0, '0, 0, '0, 0, 1, 4'd1);
      chk("s2.restore", 64'(restore_ghist_idx), 64'd33);

      // wrap: head=14, tail=2 (wrapped)
      do_reset();
      for (int i = 0; i < 14; i++) drive(1, 8'(i), 0, '0, 0, 0, '0);
      for (int i = 0; i < 14; i++) idle_commit();
      for (int i = 0; i < 4; i++) drive(1, 8'(60 + i), 0, '0, 0, 0, '0);
      chk("wrap.count4", 64'(count), 64'd4);
      drive(0, '0, 0, '0, 0, 1, 4'd15);
      chk("wrap.count", 64'(count), 64'd2);
      chk("wrap.enq_idx", 64'(enq_idx), 64'd0);
      chk("wrap.ghist", 64'(restore_ghist_idx), 64'd61);
      drive(0, '0, 0, '0, 0, 1, 4'd5);
      chk("wrap.err", 64'(squash_err), 64'd1);
      chk("wrap.err_count", 64'(count), 64'd2);

      // commit the squashed head entry in the same cycle
      drive(0, '0, 0, '0, 1, 1, 4'd14);
      chk("sqcm.count", 64'(count), 64'd0);

      // reset asserted mid-squash
      drive(1, 8'd3, 0, '0, 0, 0, '0);
      drive(1, 8'd4, 0, '0, 0, 0, '0);
      squash_en = 1; squash_idx = 4'd0;
      @(negedge clk);
      do_reset();
      squash_en = 0;
      idle();
      chk("rstsq.count", 64'(count), 64'd0);
      chk("rstsq.rv", 64'(restore_valid), 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [IDX_W-1:0] si;
         if ($urandom_range(1, 0) == 1 && mq.size() > 0)
            si = 4'((head_seq + $urandom_range(mq.size() - 1, 0)) % DEPTH);
         else
            si = 4'($urandom_range(DEPTH - 1, 0));
         drive($urandom_range(99, 0) < 60, 8'($urandom), $urandom_range(99, 0) < 10, 8'($urandom),
               $urandom_range(99, 0) < 40, $urandom_range(99, 0) < 8, si);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   task automatic idle_commit();
      drive(0, '0, 0, '0, 1, 0, '0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
